// File: rtl/clk_en_sched.sv
// clk_en_sched: per-domain clock-enable scheduler with staggered round-robin wake grants and idle gate-off.
// Latency: req sampled at edge t -> clk_en at t+1 (uncontended), ack at t+2; clk_en/ack are direct flop outputs.
// Backpressure: wake grants are limited to one per STAGGER cycles; requesters hold req until ack.
// Optional: define CLK_EN_SCHED_FORCE_ON_EN to add the force_on port (all clocks on, FSMs frozen).

module clk_en_sched #(
  parameter int N_DOM    = 4,
  parameter int IDLE_CYC = 16,
  parameter int STAGGER  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DOM-1:0] req,
  input  logic [N_DOM-1:0] busy,
  output logic [N_DOM-1:0] clk_en,
  output logic [N_DOM-1:0] ack
`ifdef CLK_EN_SCHED_FORCE_ON_EN
  ,
  input  logic             force_on
`endif
);

  localparam int CW = $clog2(IDLE_CYC + 1);
  localparam int SW = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int PW = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_PEND = 2'd1,
    ST_ON   = 2'd2,
    ST_IDLE = 2'd3
  } dom_st_t;

  dom_st_t          state_q [N_DOM];
  dom_st_t          state_d [N_DOM];
  logic [CW-1:0]    cnt_q   [N_DOM];
  logic [CW-1:0]    cnt_d   [N_DOM];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [SW-1:0]    stag_q, stag_d;
  logic [N_DOM-1:0] elig;
  logic [N_DOM-1:0] gnt;
  logic             gnt_vld;
  logic [PW-1:0]    win;
  logic [N_DOM-1:0] en_d;
  logic [N_DOM-1:0] ack_d;
  logic             frz;

`ifdef CLK_EN_SCHED_FORCE_ON_EN
  assign frz = force_on;
`else
  assign frz = 1'b0;
`endif

  // Round-robin pick of one still-requesting PEND domain, only when the stagger window has expired
  always_comb begin
    elig    = '0;
    gnt     = '0;
    gnt_vld = 1'b0;
    win     = '0;
    for (int i = 0; i < N_DOM; i++) begin
      elig[i] = (state_q[i] == ST_PEND) && req[i] && (stag_q == '0);
    end
    for (int k = 0; k < N_DOM; k++) begin : scan
      int idx;
      idx = (int'(ptr_q) + k) % N_DOM;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        win     = PW'(idx);
      end
    end
    if (gnt_vld) begin
      gnt[win] = 1'b1;
    end
  end

  // Pointer advances past the winner; stagger counter reloads on a grant and otherwise drains to 0
  always_comb begin
    ptr_d  = ptr_q;
    stag_d = stag_q;
    if (gnt_vld) begin
      ptr_d  = PW'((int'(win) + 1) % N_DOM);
      stag_d = SW'(STAGGER - 1);
    end else if (stag_q != '0) begin
      stag_d = stag_q - SW'(1);
    end
  end

  // Per-domain next-state and idle counter
  always_comb begin
    for (int i = 0; i < N_DOM; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (req[i]) state_d[i] = ST_PEND;
        end
        ST_PEND: begin
          if (!req[i]) begin
            state_d[i] = ST_OFF;
          end else if (gnt[i]) begin
            state_d[i] = ST_ON;
          end
        end
        ST_ON: begin
          if (!req[i] && !busy[i]) begin
            if (IDLE_CYC == 1) begin
              state_d[i] = ST_OFF;
              cnt_d[i]   = '0;
            end else begin
              state_d[i] = ST_IDLE;
              cnt_d[i]   = CW'(1);
            end
          end
        end
        ST_IDLE: begin
          if (req[i] || busy[i]) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CW'(IDLE_CYC)) begin
            state_d[i] = ST_OFF;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = ST_OFF;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Registered outputs: enable follows ON/IDLE; ack is the enable delayed, dropping with it
  always_comb begin
    en_d  = '0;
    ack_d = '0;
    for (int i = 0; i < N_DOM; i++) begin
      en_d[i]  = frz || (state_d[i] == ST_ON) || (state_d[i] == ST_IDLE);
      ack_d[i] = frz || (clk_en[i] && en_d[i]);
    end
  end

  // State, counters and output flops; a forced-on cycle freezes all scheduling state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_DOM; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      ptr_q  <= '0;
      stag_q <= '0;
      clk_en <= '0;
      ack    <= '0;
    end else begin
      clk_en <= en_d;
      ack    <= ack_d;
      if (!frz) begin
        for (int i = 0; i < N_DOM; i++) begin
          state_q[i] <= state_d[i];
          cnt_q[i]   <= cnt_d[i];
        end
        ptr_q  <= ptr_d;
        stag_q <= stag_d;
      end
    end
  end

endmodule

// File: tb/tb_clk_en_sched.sv
// Testbench for clk_en_sched: directed scenarios plus random req/busy traffic.
// Expected clk_en/ack come from a cycle-count based model and are queued per edge;
// a monitor pops and compares one entry after every rising edge.

module tb_clk_en_sched;

  localparam int N        = 4;
  localparam int IDLE_CYC = 16;
  localparam int STAGGER  = 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] busy;
  logic [N-1:0] clk_en;
  logic [N-1:0] ack;

  int errors = 0;
  int checks = 0;

  clk_en_sched #(.N_DOM(N), .IDLE_CYC(IDLE_CYC), .STAGGER(STAGGER)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .busy   (busy),
    .clk_en (clk_en),
    .ack    (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a domain's clock runs from its grant edge until IDLE_CYC+1 edges
  // after the last edge with req|busy high; grants are spaced by STAGGER edges.
  bit           m_on      [N];
  bit           m_pend    [N];
  int           m_last_act[N];
  int           m_ptr;
  int           m_last_g;
  int           m_edge = 0;
  logic [N-1:0] m_en  = '0;
  logic [N-1:0] m_ack = '0;

  logic [2*N-1:0] exp_q[$];

  task automatic model_edge(input logic r, input logic [N-1:0] rq, input logic [N-1:0] bz);
    bit           on0  [N];
    bit           pend0[N];
    logic [N-1:0] prev_en;
    bit           found;
    int           i;
    m_edge++;
    if (r) begin
      for (int d = 0; d < N; d++) begin
        m_on[d] = 0; m_pend[d] = 0; m_last_act[d] = 0;
      end
      m_ptr    = 0;
      m_last_g = -1000;
      m_en     = '0;
      m_ack    = '0;
      return;
    end
    prev_en = m_en;
    for (int d = 0; d < N; d++) begin
      on0[d] = m_on[d]; pend0[d] = m_pend[d];
    end
    for (int d = 0; d < N; d++) begin
      if (pend0[d] && !rq[d]) m_pend[d] = 0;
    end
    found = 0;
    if (m_edge - m_last_g >= STAGGER) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (!found && pend0[i] && rq[i]) begin
          found         = 1;
          m_on[i]       = 1;
          m_pend[i]     = 0;
          m_last_act[i] = m_edge;
          m_last_g      = m_edge;
          m_ptr         = (i + 1) % N;
        end
      end
    end
    for (int d = 0; d < N; d++) begin
      if (on0[d]) begin
        if (rq[d] || bz[d]) m_last_act[d] = m_edge;
        else if (m_edge - m_last_act[d] >= IDLE_CYC + 1) m_on[d] = 0;
      end else if (!pend0[d] && rq[d]) begin
        m_pend[d] = 1;
      end
    end
    for (int d = 0; d < N; d++) m_en[d] = m_on[d];
    m_ack = prev_en & m_en;
  endtask

  // Drive one cycle of inputs, queue the model's answer, return just after the edge
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] bz);
    @(negedge clk);
    rst  = r;
    req  = rq;
    busy = bz;
    model_edge(r, rq, bz);
    exp_q.push_back({m_en, m_ack});
    @(posedge clk);
    #1;
  endtask

  task automatic dchk(input string nm, input logic [N-1:0] ee, input logic [N-1:0] ea);
    checks++;
    if (clk_en !== ee || ack !== ea) begin
      errors++;
      $display("FAIL %s: clk_en=%b ack=%b, expected clk_en=%b ack=%b", nm, clk_en, ack, ee, ea);
    end
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, '0);
  endtask

  // Monitor: compare DUT outputs after every edge against the queued expectation
  initial begin
    logic [2*N-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({clk_en, ack} !== e) begin
          errors++;
          $display("FAIL sb t=%0t: clk_en=%b ack=%b, expected clk_en=%b ack=%b",
                   $time, clk_en, ack, e[2*N-1:N], e[N-1:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; busy = '0;

    // Reset with all requests held, then staggered grants 0,1,2,3
    for (int k = 0; k < 3; k++) step(1'b1, 4'b1111, '0);
    dchk("reset_hold", 4'b0000, 4'b0000);
    step(1'b0, 4'b1111, '0);
    dchk("rel_pend", 4'b0000, 4'b0000);
    step(1'b0, 4'b1111, '0);
    dchk("rel_g0", 4'b0001, 4'b0000);
    step(1'b0, 4'b1111, '0);
    step(1'b0, 4'b1111, '0);
    dchk("rel_g1", 4'b0011, 4'b0001);
    step(1'b0, 4'b1111, '0);
    step(1'b0, 4'b1111, '0);
    dchk("rel_g2", 4'b0111, 4'b0011);
    step(1'b0, 4'b1111, '0);
    step(1'b0, 4'b1111, '0);
    dchk("rel_g3", 4'b1111, 4'b0111);

    // Single wake of domain 2, then idle gate-off
    step(1'b1, '0, '0);
    idle_steps(3);
    step(1'b0, 4'b0100, '0);
    dchk("wake_pend", 4'b0000, 4'b0000);
    step(1'b0, 4'b0100, '0);
    dchk("wake_en", 4'b0100, 4'b0000);
    step(1'b0, 4'b0100, '0);
    dchk("wake_ack", 4'b0100, 4'b0100);
    for (int k = 0; k < 3; k++) step(1'b0, 4'b0100, 4'b0100);
    idle_steps(IDLE_CYC);
    dchk("idle_hold", 4'b0100, 4'b0100);
    idle_steps(1);
    dchk("idle_off", 4'b0000, 4'b0000);

    // Busy pulse mid-countdown restarts the idle period
    step(1'b0, 4'b0100, '0);
    step(1'b0, 4'b0100, '0);
    step(1'b0, 4'b0100, '0);
    dchk("rewake_ack", 4'b0100, 4'b0100);
    idle_steps(9);
    step(1'b0, '0, 4'b0100);
    idle_steps(IDLE_CYC);
    dchk("busy_hold", 4'b0100, 4'b0100);
    idle_steps(1);
    dchk("busy_off", 4'b0000, 4'b0000);

    // Round robin from pointer 3 with req=1011: order 3,0,1, pointer ends at 2
    step(1'b0, 4'b1011, '0);
    step(1'b0, 4'b1011, '0);
    dchk("rr_a", 4'b1000, 4'b0000);
    step(1'b0, 4'b1011, '0);
    step(1'b0, 4'b1011, '0);
    dchk("rr_b", 4'b1001, 4'b1000);
    step(1'b0, 4'b1011, '0);
    step(1'b0, 4'b1011, '0);
    dchk("rr_c", 4'b1011, 4'b1001);
    idle_steps(IDLE_CYC + 2);
    dchk("rr_alloff", 4'b0000, 4'b0000);
    step(1'b0, 4'b1111, '0);
    step(1'b0, 4'b1111, '0);
    dchk("rr_ptr", 4'b0100, 4'b0000);

    // PEND withdraw while stagger blocks; next pending domain still on schedule
    step(1'b1, '0, '0);
    step(1'b0, '0, '0);
    step(1'b0, 4'b0001, '0);
    step(1'b0, 4'b0111, '0);
    dchk("wd_g0", 4'b0001, 4'b0000);
    step(1'b0, 4'b0101, '0);
    dchk("wd_block", 4'b0001, 4'b0001);
    step(1'b0, 4'b0101, '0);
    dchk("wd_g2", 4'b0101, 4'b0001);
    step(1'b0, 4'b0101, '0);
    dchk("wd_no1", 4'b0101, 4'b0101);

    // Random traffic with occasional resets
    step(1'b1, '0, '0);
    begin
      logic [N-1:0] rq = '0;
      logic [N-1:0] bz = '0;
      for (int c = 0; c < 3000; c++) begin
        for (int d = 0; d < N; d++) begin
          if ($urandom_range(0, 9) == 0) rq[d] = ~rq[d];
          if ($urandom_range(0, 5) == 0) bz[d] = ~bz[d];
        end
        step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, rq, bz);
      end
    end

    idle_steps(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
